proj_fm_unpack: RTL and testbench
=================================

PROJ_FM_UNPACK -- requirements
Module: proj_fm_unpack

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, the width of one feature-map word.
REQ-002 SHALL have parameter READ_ADDRESSES_COUNT, default 4, the number of words packed in one wide read word.
REQ-003 SHALL have parameters RAMS, ENTRIES and OFFSET, all default 2, where FRAME_WORDS = RAMS*ENTRIES*OFFSET is the word count of one buffer.
REQ-004 SHALL have parameter BUFFER_COUNT, default 2, the number of ping-pong buffers cycled through.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as below.
REQ-006 SHALL have port in_clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port in_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit: a wide word is offered.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts the wide word.
REQ-010 SHALL have port in_rdata, input, READ_ADDRESSES_COUNT*DATA_BITS bits: the packed words, with lane 0 in bits [DATA_BITS-1:0].
REQ-011 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream accepts the word.
REQ-013 SHALL have port out_data, output, DATA_BITS bits: the current serialized word.
REQ-014 SHALL have port out_last, output, 1 bit: marks word FRAME_WORDS-1 of a buffer.
REQ-015 SHALL have port out_buf_idx, output, max(1,$clog2(BUFFER_COUNT)) bits: the buffer index of the current word.

Function
REQ-016 SHALL treat a handshake as complete when valid&&ready is sampled high on a rising in_clk edge, on either side.
REQ-017 SHALL implement the states EMPTY (no word held) and HOLD (a word is held, with lane pointer 0..READ_ADDRESSES_COUNT-1).
REQ-018 SHALL, in EMPTY, drive in_ready=1 and out_valid=0; on an input handshake it SHALL latch in_rdata, set lane=0 and go to HOLD.
REQ-019 SHALL, in HOLD, drive out_valid=1 and out_data=lane[lane] of the held word, emitting lanes in ascending order.
REQ-020 SHALL, in HOLD with an output handshake and lane<last, increment lane.
REQ-021 SHALL drive in_ready=1 in HOLD only when lane==last and out_ready==1, giving zero-bubble back-to-back transfer.
REQ-022 SHALL, on an output handshake of the last lane, reload with lane=0 if an input handshake completes on the same edge, and otherwise go to EMPTY.
REQ-023 SHALL hold out_data, out_last and out_buf_idx stable while out_valid=1 and out_ready=0.
REQ-024 SHALL count output handshakes in word_cnt over 0..FRAME_WORDS-1, wrapping to 0.
REQ-025 SHALL drive out_last=out_valid&&(word_cnt==FRAME_WORDS-1).
REQ-026 SHALL, on the handshake of the out_last word, increment out_buf_idx, wrapping from BUFFER_COUNT-1 to 0.
REQ-027 SHALL give an input-to-first-output latency of 1 cycle, with no combinational path from in_rdata to out_data.
REQ-028 SHALL fail elaboration unless FRAME_WORDS % READ_ADDRESSES_COUNT == 0 and READ_ADDRESSES_COUNT >= 1.

Reset
REQ-029 SHALL, while in_rst_n=0, force state=EMPTY, lane=0, word_cnt=0, out_buf_idx=0, out_valid=0, out_last=0, in_ready=0 and out_data=0.
REQ-030 SHALL drive in_ready=1 on the first cycle after deassertion.
REQ-031 SHALL, on a mid-word reset, discard the held word and restart at lane 0, word 0, buffer 0.

Configuration
REQ-032 SHALL, with macro PROJ_FM_UNPACK_FRAME_CNT_EN defined, add output out_frame_cnt (16 bits), reset to 0, incremented on each out_last handshake and saturating at 16'hFFFF.
REQ-033 SHALL, without PROJ_FM_UNPACK_FRAME_CNT_EN, omit the out_frame_cnt port and its logic, with all other behaviour identical.

Structure
REQ-034 SHALL take the state enum (EMPTY, HOLD) and a FRAME_WORDS/index-width helper function from the shared package proj_fm_pkg.
REQ-035 SHALL place the lane select in the sub-module proj_fm_lane_mux (combinational, parameterized by DATA_BITS and READ_ADDRESSES_COUNT).

Verification
REQ-036 SHALL check: reset then release -> out_valid=0, in_ready=1, out_buf_idx=0.
REQ-037 SHALL check: in_rdata=32'h03020100 with out_ready=1 -> out_data 00,01,02,03 on consecutive cycles, and in_ready=1 only on the 03 cycle.
REQ-038 SHALL check: back-to-back words 32'h03020100 and 32'h07060504 -> 8 gapless beats 00..07, out_last only on 07, out_buf_idx 0 then 1.
REQ-039 SHALL check: out_ready=0 for 3 cycles while 02 is shown -> out_data=02 stable, no lane advance, no input accepted.
REQ-040 SHALL check: two frames streamed -> out_buf_idx wraps 1 to 0 after the second out_last, and with the macro out_frame_cnt=2.
REQ-041 SHALL check: reset asserted while lane=2 -> outputs return to their reset values, and the next word starts at lane 0 with word_cnt=0.

Source files
------------

// File: rtl/proj_fm_pkg.sv
// Shared definitions for the feature-map unpacker: state encoding and
// sizing helpers used by the top level and the lane multiplexer.
package proj_fm_pkg;

  // EMPTY: no wide word held; HOLD: a wide word is being serialized.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } fm_state_e;

  // Number of words making up one ping-pong buffer.
  function automatic int fm_frame_words(input int rams, input int entries, input int offset);
    return rams * entries * offset;
  endfunction

  // Index width for a count of n items, never narrower than one bit.
  function automatic int fm_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/proj_fm_lane_mux.sv
// Combinational lane selector: picks one DATA_BITS lane out of a packed
// wide word. Lane 0 sits in the least significant bits.
module proj_fm_lane_mux
  import proj_fm_pkg::*;
#(
  parameter int DATA_BITS            = 8,
  parameter int READ_ADDRESSES_COUNT = 4,
  parameter int SEL_BITS             = fm_idx_bits(READ_ADDRESSES_COUNT)
) (
  input  logic [READ_ADDRESSES_COUNT*DATA_BITS-1:0] word,
  input  logic [SEL_BITS-1:0]                       sel,
  output logic [DATA_BITS-1:0]                      data
);

  logic [DATA_BITS-1:0] lanes [READ_ADDRESSES_COUNT];

  for (genvar gi = 0; gi < READ_ADDRESSES_COUNT; gi++) begin : g_lane
    assign lanes[gi] = word[gi*DATA_BITS +: DATA_BITS];
  end

  // Compare-and-select so a select value past the last lane yields zero
  // instead of an out-of-range array read.
  always_comb begin
    data = '0;
    for (int i = 0; i < READ_ADDRESSES_COUNT; i++) begin
      if (sel == SEL_BITS'(i)) data = lanes[i];
    end
  end

endmodule

// File: rtl/proj_fm_unpack.sv
// Feature-map unpacker: accepts wide words of READ_ADDRESSES_COUNT packed
// lanes and serializes them one lane per output handshake, tagging the last
// word of each buffer and cycling a ping-pong buffer index.
// Optional feature: define PROJ_FM_UNPACK_FRAME_CNT_EN to add a saturating
// 16-bit frame counter output (out_frame_cnt).
module proj_fm_unpack
  import proj_fm_pkg::*;
#(
  parameter int DATA_BITS            = 8,
  parameter int READ_ADDRESSES_COUNT = 4,
  parameter int RAMS                 = 2,
  parameter int ENTRIES              = 2,
  parameter int OFFSET               = 2,
  parameter int BUFFER_COUNT         = 2
) (
  input  logic                                      in_clk,
  input  logic                                      in_rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [READ_ADDRESSES_COUNT*DATA_BITS-1:0] in_rdata,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DATA_BITS-1:0]                      out_data,
  output logic                                      out_last,
  output logic [fm_idx_bits(BUFFER_COUNT)-1:0]      out_buf_idx
`ifdef PROJ_FM_UNPACK_FRAME_CNT_EN
  ,
  output logic [15:0]                               out_frame_cnt
`endif
);

  localparam int FRAME_WORDS = fm_frame_words(RAMS, ENTRIES, OFFSET);
  localparam int LANE_BITS   = fm_idx_bits(READ_ADDRESSES_COUNT);
  localparam int CNT_BITS    = fm_idx_bits(FRAME_WORDS);
  localparam int BUF_BITS    = fm_idx_bits(BUFFER_COUNT);

  localparam logic [LANE_BITS-1:0] LANE_LAST = LANE_BITS'(READ_ADDRESSES_COUNT - 1);
  localparam logic [CNT_BITS-1:0]  CNT_LAST  = CNT_BITS'(FRAME_WORDS - 1);
  localparam logic [BUF_BITS-1:0]  BUF_LAST  = BUF_BITS'(BUFFER_COUNT - 1);

  // A buffer must hold a whole number of wide words.
  if (READ_ADDRESSES_COUNT < 1 || (FRAME_WORDS % READ_ADDRESSES_COUNT) != 0) begin : g_bad_cfg
    $error("proj_fm_unpack: FRAME_WORDS must be a multiple of READ_ADDRESSES_COUNT");
  end

  fm_state_e                                 state_reg, state_next;
  logic [LANE_BITS-1:0]                      lane_reg, lane_next;
  logic [READ_ADDRESSES_COUNT*DATA_BITS-1:0] word_reg;
  logic [CNT_BITS-1:0]                       word_cnt_reg;
  logic [BUF_BITS-1:0]                       buf_idx_reg;
  logic                                      load;
  logic                                      in_hs;
  logic                                      out_hs;
  logic                                      lane_is_last;

  assign lane_is_last = (lane_reg == LANE_LAST);

  // Upstream is accepted when idle, or when the final lane leaves this cycle
  // so the next word follows without a bubble. Forced low while in reset.
  assign in_ready  = in_rst_n && ((state_reg == ST_EMPTY) ||
                                  (lane_is_last && out_ready));
  assign out_valid = (state_reg == ST_HOLD);
  assign out_last  = out_valid && (word_cnt_reg == CNT_LAST);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign out_buf_idx = buf_idx_reg;

  // Output lane comes from the registered word only: no in_rdata->out_data path.
  proj_fm_lane_mux #(
    .DATA_BITS            (DATA_BITS),
    .READ_ADDRESSES_COUNT (READ_ADDRESSES_COUNT),
    .SEL_BITS             (LANE_BITS)
  ) u_lane_mux (
    .word (word_reg),
    .sel  (lane_reg),
    .data (out_data)
  );

  // Next-state, lane advance and word-load decision.
  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    load       = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (in_hs) begin
          state_next = ST_HOLD;
          lane_next  = '0;
          load       = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_hs) begin
          if (!lane_is_last) begin
            lane_next = lane_reg + 1'b1;
          end else if (in_hs) begin
            lane_next = '0;
            load      = 1'b1;
          end else begin
            state_next = ST_EMPTY;
            lane_next  = '0;
          end
        end
      end
      default: begin
        state_next = ST_EMPTY;
        lane_next  = '0;
      end
    endcase
  end

  // State, lane pointer and held wide word.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_reg <= ST_EMPTY;
      lane_reg  <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      if (load) word_reg <= in_rdata;
    end
  end

  // Word position inside the buffer and ping-pong buffer index.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      word_cnt_reg <= '0;
      buf_idx_reg  <= '0;
    end else if (out_hs) begin
      word_cnt_reg <= (word_cnt_reg == CNT_LAST) ? '0 : word_cnt_reg + 1'b1;
      if (out_last) begin
        buf_idx_reg <= (buf_idx_reg == BUF_LAST) ? '0 : buf_idx_reg + 1'b1;
      end
    end
  end

`ifdef PROJ_FM_UNPACK_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  // Completed buffers, saturating rather than wrapping.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      frame_cnt_reg <= '0;
    end else if (out_hs && out_last && (frame_cnt_reg != 16'hFFFF)) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign out_frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_proj_fm_unpack.sv
// Directed self-checking bench for proj_fm_unpack at default parameters
// (4 lanes of 8 bits, 8 words per buffer, 2 buffers).
module tb_proj_fm_unpack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [0:0]  out_buf_idx;
`ifdef PROJ_FM_UNPACK_FRAME_CNT_EN
  logic [15:0] out_frame_cnt;
`endif

  int total = 0;
  int bad   = 0;

  proj_fm_unpack dut (
    .in_clk      (clk),
    .in_rst_n    (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rdata    (in_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_buf_idx (out_buf_idx)
`ifdef PROJ_FM_UNPACK_FRAME_CNT_EN
    ,
    .out_frame_cnt (out_frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed word whose lanes hold base, base+1, base+2, base+3.
  function automatic logic [31:0] word_of(input int base);
    return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_rdata  = '0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_rdata  = 32'hDEADBEEF;
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid got=%b exp=0", out_valid); end
    total++; if (out_buf_idx !== 1'b0) begin bad++; $display("FAIL rel_buf_idx got=%b exp=0", out_buf_idx); end
    $display("reset: in_ready=%b out_valid=%b buf=%b", in_ready, out_valid, out_buf_idx);
  endtask

  task automatic test_single();
    do_reset();
    in_valid  = 1'b1;
    in_rdata  = 32'h03020100;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_accept got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      $display("single beat %0d: data=%h in_ready=%b last=%b", i, out_data, in_ready, out_last);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid beat=%0d got=%b exp=1", i, out_valid); end
      total++; if (out_data !== 8'(i)) begin bad++; $display("FAIL single_data beat=%0d got=%h exp=%h", i, out_data, 8'(i)); end
      total++; if (in_ready !== (i == 3)) begin bad++; $display("FAIL single_in_ready beat=%0d got=%b exp=%b", i, in_ready, (i == 3)); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL single_last beat=%0d got=%b exp=0", i, out_last); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid  = 1'b1;
    in_rdata  = 32'h03020100;
    out_ready = 1'b1;
    step();
    for (int b = 0; b < 8; b++) begin
      in_valid = (b < 4);
      in_rdata = 32'h07060504;
      #1;
      $display("b2b beat %0d: data=%h last=%b buf=%b", b, out_data, out_last, out_buf_idx);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid beat=%0d got=%b exp=1", b, out_valid); end
      total++; if (out_data !== 8'(b)) begin bad++; $display("FAIL b2b_data beat=%0d got=%h exp=%h", b, out_data, 8'(b)); end
      total++; if (out_last !== (b == 7)) begin bad++; $display("FAIL b2b_last beat=%0d got=%b exp=%b", b, out_last, (b == 7)); end
      total++; if (out_buf_idx !== 1'b0) begin bad++; $display("FAIL b2b_buf beat=%0d got=%b exp=0", b, out_buf_idx); end
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    total++; if (out_buf_idx !== 1'b1) begin bad++; $display("FAIL b2b_buf_after got=%b exp=1", out_buf_idx); end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid  = 1'b1;
    in_rdata  = 32'h03020100;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    // Now showing lane 2; stall with a new word pending upstream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_rdata  = 32'h07060504;
    for (int c = 0; c < 3; c++) begin
      #1;
      $display("stall cycle %0d: data=%h valid=%b in_ready=%b", c, out_data, out_valid, in_ready);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", c, out_valid); end
      total++; if (out_data !== 8'h02) begin bad++; $display("FAIL stall_data cyc=%0d got=%h exp=02", c, out_data); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (out_data !== 8'h02) begin bad++; $display("FAIL stall_resume got=%h exp=02", out_data); end
    step();
    total++; if (out_data !== 8'h03) begin bad++; $display("FAIL stall_next got=%h exp=03", out_data); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_accept got=%b exp=0", out_valid); end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    in_valid  = 1'b1;
    in_rdata  = word_of(0);
    out_ready = 1'b1;
    step();
    for (int b = 0; b < 16; b++) begin
      in_valid = ((b / 4) < 3);
      in_rdata = word_of(4 * (b / 4 + 1));
      #1;
      $display("wrap beat %0d: data=%h last=%b buf=%b", b, out_data, out_last, out_buf_idx);
      total++; if (out_data !== 8'(b)) begin bad++; $display("FAIL wrap_data beat=%0d got=%h exp=%h", b, out_data, 8'(b)); end
      total++; if (in_ready !== ((b % 4) == 3)) begin bad++; $display("FAIL wrap_in_ready beat=%0d got=%b exp=%b", b, in_ready, ((b % 4) == 3)); end
      total++; if (out_last !== ((b % 8) == 7)) begin bad++; $display("FAIL wrap_last beat=%0d got=%b exp=%b", b, out_last, ((b % 8) == 7)); end
      total++; if (out_buf_idx !== 1'(b / 8)) begin bad++; $display("FAIL wrap_buf beat=%0d got=%b exp=%b", b, out_buf_idx, 1'(b / 8)); end
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain got=%b exp=0", out_valid); end
    total++; if (out_buf_idx !== 1'b0) begin bad++; $display("FAIL wrap_buf_after got=%b exp=0", out_buf_idx); end
`ifdef PROJ_FM_UNPACK_FRAME_CNT_EN
    total++; if (out_frame_cnt !== 16'd2) begin bad++; $display("FAIL wrap_frame_cnt got=%0d exp=2", out_frame_cnt); end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid  = 1'b1;
    in_rdata  = 32'h03020100;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    total++; if (out_data !== 8'h02) begin bad++; $display("FAIL mid_pre got=%h exp=02", out_data); end
    rst_n = 1'b0;
    #1;
    $display("mid reset: valid=%b data=%h in_ready=%b", out_valid, out_data, in_ready);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL mid_data got=%h exp=00", out_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL mid_last got=%b exp=0", out_last); end
    total++; if (out_buf_idx !== 1'b0) begin bad++; $display("FAIL mid_buf got=%b exp=0", out_buf_idx); end
    step();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_rdata = word_of(4);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b exp=1", in_ready); end
    step();
    for (int b = 0; b < 8; b++) begin
      in_valid = (b < 4);
      in_rdata = word_of(8);
      #1;
      $display("post-reset beat %0d: data=%h last=%b", b, out_data, out_last);
      total++; if (out_data !== 8'(b + 4)) begin bad++; $display("FAIL mid_data beat=%0d got=%h exp=%h", b, out_data, 8'(b + 4)); end
      total++; if (out_last !== (b == 7)) begin bad++; $display("FAIL mid_last beat=%0d got=%b exp=%b", b, out_last, (b == 7)); end
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_rdata  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_frame_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
